// File: rtl/mem_arbiter.sv
// Single-bus arbiter between instruction fetch and data load/store.
// Serves one transaction at a time, returns ready pulses, and aborts hung accesses.
module mem_arbiter #(
  parameter int unsigned TIMEOUT       = 255,
  parameter int unsigned DATA_PRIORITY = 1
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_sel,
  output logic        iready,
  output logic [31:0] instr,
  output logic        dready,
  output logic [31:0] d_rdata,
  output logic        bus_err
);

  localparam int unsigned      CNT_W      = 16;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(TIMEOUT - 1);
  localparam bit               DATA_FIRST = (DATA_PRIORITY != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_ren_q, mem_ren_d;
  logic               mem_wen_q, mem_wen_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [3:0]         mem_sel_q, mem_sel_d;
  logic               iready_q, iready_d;
  logic               dready_q, dready_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        d_rdata_q, d_rdata_d;
  logic               bus_err_q, bus_err_d;
  logic               d_req_c;

  // State and output registers
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_sel_q   <= '0;
      iready_q    <= 1'b0;
      dready_q    <= 1'b0;
      instr_q     <= '0;
      d_rdata_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_sel_q   <= mem_sel_d;
      iready_q    <= iready_d;
      dready_q    <= dready_d;
      instr_q     <= instr_d;
      d_rdata_q   <= d_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Next-state, grant and completion logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_ren_d   = mem_ren_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_sel_d   = mem_sel_q;
    iready_d    = 1'b0;
    dready_d    = 1'b0;
    instr_d     = instr_q;
    d_rdata_d   = d_rdata_q;
    bus_err_d   = bus_err_q;
    d_req_c     = d_ren | d_wen;

    case (state_q)
      IDLE: begin
        // A simultaneous read+write request is performed as a write
        if (d_req_c && (DATA_FIRST || !i_req)) begin
          state_d     = DBUS;
          cnt_d       = '0;
          mem_wen_d   = d_wen;
          mem_ren_d   = d_ren & ~d_wen;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_sel_d   = d_wen ? d_sel : 4'hF;
        end else if (i_req) begin
          state_d     = IBUS;
          cnt_d       = '0;
          mem_ren_d   = 1'b1;
          mem_wen_d   = 1'b0;
          mem_addr_d  = {i_addr[31:2], 2'b00};
          mem_wdata_d = '0;
          mem_sel_d   = 4'hF;
        end
      end
      IBUS, DBUS: begin
        // Ack wins over a watchdog expiry landing in the same cycle
        if (mem_ack || (cnt_q == LAST_CNT)) begin
          state_d   = DONE;
          mem_ren_d = 1'b0;
          mem_wen_d = 1'b0;
          if (state_q == IBUS) iready_d = 1'b1;
          else                 dready_d = 1'b1;
          if (mem_ack) begin
            if (state_q == IBUS)  instr_d   = mem_rdata;
            else if (!mem_wen_q)  d_rdata_d = mem_rdata;
          end else begin
            bus_err_d = 1'b1;
          end
        end
        if (!mem_ack && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_ren   = mem_ren_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_sel   = mem_sel_q;
  assign iready    = iready_q;
  assign dready    = dready_q;
  assign instr     = instr_q;
  assign d_rdata   = d_rdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner
// sequences, and random traffic against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int TMO = 4;

  logic        clk, nRST;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_ren, d_wen;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_sel;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic        iready, dready, bus_err;
  logic [31:0] instr, d_rdata;

  mem_arbiter #(.TIMEOUT(TMO), .DATA_PRIORITY(1)) dut (
    .clk(clk), .nRST(nRST),
    .i_req(i_req), .i_addr(i_addr),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_sel(mem_sel),
    .iready(iready), .instr(instr), .dready(dready), .d_rdata(d_rdata),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the core should currently observe
  logic [31:0] m_instr  = '0;
  logic [31:0] m_drdata = '0;
  logic        m_err    = 1'b0;

  typedef struct {
    bit          fetch;
    bit          ren;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          lat;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_instr;
    logic [31:0] exp_drdata;
  } vec_t;

  localparam int NV = 6;
  vec_t tbl [NV];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance to 1ns after the next rising edge; ready pulses must be exclusive
  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if (iready && dready) begin
      errors++;
      $display("FAIL ready_excl: iready=%b dready=%b expected not both at %0t", iready, dready, $time);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk1({nm, "_ren"}, mem_ren, 1'b0);
    chk1({nm, "_wen"}, mem_wen, 1'b0);
    chk32({nm, "_addr"}, mem_addr, 32'h0);
    chk32({nm, "_wdata"}, mem_wdata, 32'h0);
    chk32({nm, "_sel"}, 32'(mem_sel), 32'h0);
    chk1({nm, "_iready"}, iready, 1'b0);
    chk1({nm, "_dready"}, dready, 1'b0);
    chk32({nm, "_instr"}, instr, 32'h0);
    chk32({nm, "_drdata"}, d_rdata, 32'h0);
    chk1({nm, "_err"}, bus_err, 1'b0);
  endtask

  // Wait for the bus strobe, check it, act as memory (ack after lat cycles, or never
  // when lat >= TMO), check the ready cycle against the model, then drop the request.
  task automatic serve(input bit is_fetch, input bit is_write, input logic [31:0] exp_addr,
                       input logic [3:0] exp_sel, input logic [31:0] exp_wdata, input int lat,
                       input logic [31:0] rd, input string tag, output int waited);
    bit seen = 1'b0;
    waited = 0;
    while (!seen && waited < 4) begin
      tick();
      waited++;
      seen = mem_ren | mem_wen;
    end
    chk1({tag, "_grant"}, seen, 1'b1);
    if (!seen) begin
      i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
      return;
    end
    chk1({tag, "_ren"}, mem_ren, !is_write);
    chk1({tag, "_wen"}, mem_wen, is_write);
    chk32({tag, "_addr"}, mem_addr, exp_addr);
    chk32({tag, "_sel"}, 32'(mem_sel), 32'(exp_sel));
    if (is_write) chk32({tag, "_wdata"}, mem_wdata, exp_wdata);
    if (lat < TMO) begin
      repeat (lat) begin
        tick();
        chk1({tag, "_hold"}, mem_ren | mem_wen, 1'b1);
      end
      mem_ack = 1'b1;
      mem_rdata = rd;
      tick();
      mem_ack = 1'b0;
      mem_rdata = $urandom;
    end else begin
      repeat (TMO - 1) begin
        tick();
        chk1({tag, "_hold"}, mem_ren | mem_wen, 1'b1);
      end
      tick();
    end
    chk1({tag, "_strobe_off"}, mem_ren | mem_wen, 1'b0);
    chk1({tag, "_iready"}, iready, is_fetch);
    chk1({tag, "_dready"}, dready, !is_fetch);
    if (lat < TMO) begin
      if (is_fetch)       m_instr  = rd;
      else if (!is_write) m_drdata = rd;
    end else begin
      m_err = 1'b1;
    end
    chk32({tag, "_instr"}, instr, m_instr);
    chk32({tag, "_drdata"}, d_rdata, m_drdata);
    chk1({tag, "_err"}, bus_err, m_err);
    if (is_fetch) i_req = 1'b0;
    else begin d_ren = 1'b0; d_wen = 1'b0; end
    tick();
    chk1({tag, "_pulse_end"}, iready | dready, 1'b0);
  endtask

  int          w, op, last, npulse;
  int          lat;
  logic [31:0] lastrd, rd;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 2, 32'h0050_0093,
               32'h0000_0104, 4'hF, 32'h0050_0093, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_1007, 32'h0, 4'h0, 0, 32'h1234_5678,
               32'h0000_1004, 4'hF, 32'h1234_5678, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h1, 1, 32'hCAFE_F00D,
               32'h0000_2000, 4'hF, 32'h1234_5678, 32'hCAFE_F00D};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 32'h0000_2002, 32'hDEAD_BEEF, 4'h3, 0, 32'h5555_5555,
               32'h0000_2002, 4'h3, 32'h1234_5678, 32'hCAFE_F00D};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_3001, 32'h0102_0304, 4'hC, 3, 32'h7777_7777,
               32'h0000_3001, 4'hC, 32'h1234_5678, 32'hCAFE_F00D};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_4003, 32'h0, 4'h0, 1, 32'h89AB_CDEF,
               32'h0000_4003, 4'hF, 32'h1234_5678, 32'h89AB_CDEF};

    nRST = 1'b0; i_req = 1'b0; i_addr = '0; d_ren = 1'b0; d_wen = 1'b0;
    d_addr = '0; d_wdata = '0; d_sel = '0; mem_ack = 1'b0; mem_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    nRST = 1'b1;
    tick();
    chk1("post_reset_idle", mem_ren | mem_wen, 1'b0);

    // Directed single-transaction vectors
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].fetch) begin
        i_req = 1'b1; i_addr = tbl[i].addr;
      end else begin
        d_ren = tbl[i].ren; d_wen = tbl[i].wen; d_addr = tbl[i].addr;
        d_wdata = tbl[i].wdata; d_sel = tbl[i].sel;
      end
      serve(tbl[i].fetch, tbl[i].wen, tbl[i].exp_addr, tbl[i].exp_sel, tbl[i].wdata,
            tbl[i].lat, tbl[i].rdata, "vec", w);
      chk32("vec_tbl_instr", instr, tbl[i].exp_instr);
      chk32("vec_tbl_drdata", d_rdata, tbl[i].exp_drdata);
    end

    // Simultaneous requests: data first, fetch granted in the cycle after DONE
    i_req = 1'b1; i_addr = 32'h0000_0200;
    d_ren = 1'b1; d_wen = 1'b0; d_addr = 32'h0000_2000; d_sel = 4'h0;
    serve(1'b0, 1'b0, 32'h0000_2000, 4'hF, 32'h0, 0, 32'h1111_2222, "prio_d", w);
    chk1("prio_idle_gap", mem_ren | mem_wen, 1'b0);
    serve(1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'h0, 1, 32'h00A0_0513, "prio_i", w);
    chk32("prio_fetch_start", 32'(w), 32'd1);

    // Watchdog expiry on a fetch, then bus_err must stay set
    i_req = 1'b1; i_addr = 32'h0000_0300;
    serve(1'b1, 1'b0, 32'h0000_0300, 4'hF, 32'h0, 99, 32'hBAD0_BAD0, "tmo", w);
    d_ren = 1'b1; d_addr = 32'h0000_2100;
    serve(1'b0, 1'b0, 32'h0000_2100, 4'hF, 32'h0, 0, 32'h1357_9BDF, "tmo_after", w);

    // Spurious ack while idle
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    chk1("spur_strobe", mem_ren | mem_wen, 1'b0);
    chk1("spur_ready", iready | dready, 1'b0);
    chk32("spur_instr", instr, m_instr);
    chk32("spur_drdata", d_rdata, m_drdata);
    tick();
    chk1("spur_still_idle", mem_ren | mem_wen, 1'b0);

    // Back-to-back fetches with i_req held: one iready every 3 cycles
    i_req = 1'b1; i_addr = 32'h0000_0400;
    last = -1; npulse = 0; lastrd = '0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (iready) begin
        npulse++;
        if (last >= 0) chk32("b2b_gap", 32'(c - last), 32'd3);
        last = c;
      end
      if (mem_ren) begin
        chk32("b2b_addr", mem_addr, 32'h0000_0400);
        mem_ack = 1'b1; mem_rdata = 32'h0000_1000 + 32'(c); lastrd = mem_rdata;
      end else begin
        mem_ack = 1'b0;
      end
    end
    i_req = 1'b0; mem_ack = 1'b0;
    chk32("b2b_pulses", 32'(npulse), 32'd4);
    m_instr = lastrd;
    chk32("b2b_instr", instr, m_instr);
    tick();
    chk1("b2b_idle", mem_ren | mem_wen, 1'b0);

    // Asynchronous reset in the middle of a write; held request is re-served
    d_wen = 1'b1; d_ren = 1'b0; d_addr = 32'h0000_5000; d_sel = 4'hF; d_wdata = 32'hA5A5_A5A5;
    w = 0;
    while (!mem_wen && w < 4) begin
      tick();
      w++;
    end
    chk1("rst_mid_wen", mem_wen, 1'b1);
    #2;
    nRST = 1'b0;
    #1;
    chk_all_zero("rst_async");
    @(posedge clk);
    #1;
    nRST = 1'b1;
    m_instr = '0; m_drdata = '0; m_err = 1'b0;
    serve(1'b0, 1'b1, 32'h0000_5000, 4'hF, 32'hA5A5_A5A5, 1, 32'h0, "rst_reserve", w);

    // Random traffic: requesters hold until served; priority and latency from the model
    for (int t = 0; t < 200; t++) begin
      if (!i_req && $urandom_range(0, 1) == 1) begin
        i_req = 1'b1; i_addr = $urandom;
      end
      if (!(d_ren || d_wen) && $urandom_range(0, 1) == 1) begin
        op = int'($urandom_range(0, 2));
        d_ren = (op != 1); d_wen = (op != 0);
        d_addr = $urandom; d_wdata = $urandom; d_sel = 4'($urandom);
      end
      if (!i_req && !(d_ren || d_wen)) begin
        i_req = 1'b1; i_addr = $urandom;
      end
      lat = int'($urandom_range(0, 5));
      rd = $urandom;
      if (d_ren || d_wen)
        serve(1'b0, d_wen, d_addr, d_wen ? d_sel : 4'hF, d_wdata, lat, rd, "rnd_d", w);
      else
        serve(1'b1, 1'b0, {i_addr[31:2], 2'b00}, 4'hF, 32'h0, lat, rd, "rnd_i", w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: simulation did not reach its summary");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
